// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the iterative divider.
package div_pkg;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   // K: CALC edges per operation; counter must be able to hold K.
   function automatic int div_k(input int width, input int steps);
      return width / steps;
   endfunction

   function automatic int div_cw(input int width, input int steps);
      return $clog2(width / steps + 1);
   endfunction

endpackage

// File: rtl/div_iter_if.sv
// Request/result bundle between the execute stage and the divider.
interface div_iter_if #(parameter int WIDTH = 32);
   logic                 signed_i;
   logic [WIDTH-1:0]     opdata1_i;
   logic [WIDTH-1:0]     opdata2_i;
   logic                 start_i;
   logic                 annul_i;
   logic                 ack_i;
   logic                 busy_o;
   logic                 ready_o;
   logic                 div_zero_o;
   logic [2*WIDTH-1:0]   result_o;

   modport master (output signed_i, opdata1_i, opdata2_i, start_i, annul_i, ack_i,
                   input  busy_o, ready_o, div_zero_o, result_o);
   modport slave  (input  signed_i, opdata1_i, opdata2_i, start_i, annul_i, ack_i,
                   output busy_o, ready_o, div_zero_o, result_o);
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
module div_step #(parameter int WIDTH = 32) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] div_i,
   input  logic             bit_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_o
);
   logic [WIDTH:0] trial;

   // rem_i < div_i keeps the shifted value below 2*div, so WIDTH+1 bits resolve the sign.
   assign trial = {rem_i, bit_i} - {1'b0, div_i};
   assign q_o   = ~trial[WIDTH];
   assign rem_o = q_o ? trial[WIDTH-1:0] : {rem_i[WIDTH-2:0], bit_i};
endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider, STEPS quotient bits per cycle, result held until ack/annul.
// Optional early-out for |dividend| < |divisor| enabled by defining DIV_EARLY_OUT_EN.
module div_iter
   import div_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEPS = 1
) (
   input  logic      clk,
   input  logic      resetn,
   div_iter_if.slave bus
);
   localparam int K  = div_k(WIDTH, STEPS);
   localparam int CW = div_cw(WIDTH, STEPS);

   if (WIDTH < 8 || !(STEPS == 1 || STEPS == 2 || STEPS == 4) || (WIDTH % STEPS) != 0)
   begin : g_bad_cfg
      $error("div_iter: unsupported WIDTH/STEPS combination");
   end

   state_t             state, state_nx;
   logic [CW-1:0]      cnt;
   logic               neg_a, neg_b, dz;
   logic [WIDTH-1:0]   rem, dvd, dsr, rem_nx, dvd_nx;
   logic [WIDTH-1:0]   mag_a, mag_b, quo_fix, rem_fix;
   logic [2*WIDTH-1:0] result;
   logic               acc, b_zero, early;

   assign mag_a  = (bus.signed_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
   assign mag_b  = (bus.signed_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;
   assign b_zero = (bus.opdata2_i == '0);
   assign acc    = (state == IDLE) && bus.start_i && !bus.annul_i;

`ifdef DIV_EARLY_OUT_EN
   assign early = (mag_a < mag_b);
`else
   assign early = 1'b0;
`endif

   for (genvar i = 0; i < STEPS; i++) begin : g_step
      logic [WIDTH-1:0] r_in, d_in, r_out, d_out;
      logic             q;
      if (i == 0) begin : g_head
         assign r_in = rem;
         assign d_in = dvd;
      end else begin : g_link
         assign r_in = g_step[i-1].r_out;
         assign d_in = g_step[i-1].d_out;
      end
      div_step #(.WIDTH(WIDTH)) u_step (
         .rem_i (r_in),
         .div_i (dsr),
         .bit_i (d_in[WIDTH-1]),
         .rem_o (r_out),
         .q_o   (q)
      );
      assign d_out = {d_in[WIDTH-2:0], q};
   end
   assign rem_nx = g_step[STEPS-1].r_out;
   assign dvd_nx = g_step[STEPS-1].d_out;

   // Divide-by-zero result bypasses sign correction entirely.
   assign quo_fix = (!dz && (neg_a ^ neg_b)) ? -dvd : dvd;
   assign rem_fix = (!dz && neg_a) ? -rem : rem;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (acc) state_nx = (b_zero || early) ? FIX : CALC;
         CALC: if (bus.annul_i) state_nx = IDLE;
               else if (cnt == CW'(K - 1)) state_nx = FIX;
         FIX:  state_nx = bus.annul_i ? IDLE : DONE;
         DONE: if (bus.ack_i || bus.annul_i) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt    <= '0;
         neg_a  <= 1'b0;
         neg_b  <= 1'b0;
         dz     <= 1'b0;
         rem    <= '0;
         dvd    <= '0;
         dsr    <= '0;
         result <= '0;
      end else begin
         case (state)
            IDLE: if (acc) begin
               neg_a <= bus.signed_i & bus.opdata1_i[WIDTH-1];
               neg_b <= bus.signed_i & bus.opdata2_i[WIDTH-1];
               dz    <= b_zero;
               dsr   <= mag_b;
               cnt   <= '0;
               // Zero divisor parks the raw dividend as remainder and all-ones as quotient.
               if (b_zero) begin
                  rem <= bus.opdata1_i;
                  dvd <= '1;
               end else if (early) begin
                  rem <= mag_a;
                  dvd <= '0;
               end else begin
                  rem <= '0;
                  dvd <= mag_a;
               end
            end
            CALC: begin
               rem <= rem_nx;
               dvd <= dvd_nx;
               cnt <= cnt + CW'(1);
            end
            FIX: if (!bus.annul_i) result <= {rem_fix, quo_fix};
            default: ;
         endcase
      end
   end

   assign bus.busy_o     = (state != IDLE);
   assign bus.ready_o    = (state == DONE);
   assign bus.div_zero_o = dz && (state == DONE);
   assign bus.result_o   = result;
endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: one STEPS=1 and one STEPS=2 instance, WIDTH=32.
module tb_div_iter;
   localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
   localparam int EO1 = 1;
   localparam int EO2 = 1;
`else
   localparam int EO1 = 33;
   localparam int EO2 = 17;
`endif

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;

   div_iter_if #(.WIDTH(W)) bi1 ();
   div_iter_if #(.WIDTH(W)) bi2 ();

   div_iter #(.WIDTH(W), .STEPS(1)) u_dut1 (.clk(clk), .resetn(resetn), .bus(bi1.slave));
   div_iter #(.WIDTH(W), .STEPS(2)) u_dut2 (.clk(clk), .resetn(resetn), .bus(bi2.slave));

   typedef struct {
      logic [2*W-1:0] res;
      logic           dz;
      int             due;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];
   exp_t e1, e2, et;
   logic rp1 = 1'b0;
   logic rp2 = 1'b0;

   task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitors: compare on every rising ready_o, including arrival cycle.
   always @(negedge clk) begin
      if (resetn && bi1.ready_o && !rp1) begin
         if (q1.size() == 0) chk("unexpected_ready1", 1, 0);
         else begin
            e1 = q1.pop_front();
            chk("result1", bi1.result_o, e1.res);
            chk("div_zero1", {63'd0, bi1.div_zero_o}, {63'd0, e1.dz});
            chk("latency1", cyc, e1.due);
         end
      end
      rp1 <= bi1.ready_o;
   end

   always @(negedge clk) begin
      if (resetn && bi2.ready_o && !rp2) begin
         if (q2.size() == 0) chk("unexpected_ready2", 1, 0);
         else begin
            e2 = q2.pop_front();
            chk("result2", bi2.result_o, e2.res);
            chk("div_zero2", {63'd0, bi2.div_zero_o}, {63'd0, e2.dz});
            chk("latency2", cyc, e2.due);
         end
      end
      rp2 <= bi2.ready_o;
   end

   function automatic logic rdy(input bit s2);
      return s2 ? bi2.ready_o : bi1.ready_o;
   endfunction

   function automatic logic bsy(input bit s2);
      return s2 ? bi2.busy_o : bi1.busy_o;
   endfunction

   function automatic logic [2*W-1:0] res(input bit s2);
      return s2 ? bi2.result_o : bi1.result_o;
   endfunction

   task automatic drive(input bit s2, input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic st, input logic an, input logic ak);
      if (s2) begin
         bi2.signed_i = sg; bi2.opdata1_i = a; bi2.opdata2_i = b;
         bi2.start_i = st; bi2.annul_i = an; bi2.ack_i = ak;
      end else begin
         bi1.signed_i = sg; bi1.opdata1_i = a; bi1.opdata2_i = b;
         bi1.start_i = st; bi1.annul_i = an; bi1.ack_i = ak;
      end
   endtask

   task automatic issue(input bit s2, input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] rem, input logic [W-1:0] quo, input logic dz, input int lat);
      drive(s2, sg, a, b, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      drive(s2, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      et.res = {rem, quo};
      et.dz  = dz;
      et.due = cyc + lat;
      if (s2) q2.push_back(et);
      else    q1.push_back(et);
   endtask

   task automatic finish_op(input bit s2, input int hold, input logic [2*W-1:0] exp_res);
      for (int i = 0; i < 64; i++) begin
         if (rdy(s2)) break;
         @(negedge clk);
      end
      if (!rdy(s2)) begin
         chk("ready_timeout", 0, 1);
         return;
      end
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         chk("held_ready", {63'd0, rdy(s2)}, 1);
         chk("held_result", res(s2), exp_res);
      end
      drive(s2, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      drive(s2, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      chk("busy_after_ack", {63'd0, bsy(s2)}, 0);
      chk("ready_after_ack", {63'd0, rdy(s2)}, 0);
      chk("result_kept", res(s2), exp_res);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      drive(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      drive(1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      #12;
      chk("rst_busy", {63'd0, bi1.busy_o}, 0);
      chk("rst_ready", {63'd0, bi1.ready_o}, 0);
      chk("rst_dz", {63'd0, bi1.div_zero_o}, 0);
      chk("rst_result", bi1.result_o, 0);
      chk("rst_ready2", {63'd0, bi2.ready_o}, 0);
      @(negedge clk); resetn = 1'b1;
      @(posedge clk); #1;

      // annul in IDLE blocks start
      drive(0, 1'b0, 32'd10, 32'd2, 1'b1, 1'b1, 1'b0);
      @(posedge clk); #1;
      drive(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      chk("annul_blocks_start", {63'd0, bi1.busy_o}, 0);

      // 100/7 with a stray start mid-calculation that must be ignored
      issue(0, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
      chk("busy_after_accept", {63'd0, bi1.busy_o}, 1);
      repeat (5) @(posedge clk); #1;
      drive(0, 1'b0, 32'd1, 32'd1, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      drive(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      finish_op(0, 0, {32'd2, 32'd14});

      issue(0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
      finish_op(0, 0, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      issue(0, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 33);
      finish_op(0, 0, {32'd1, 32'hFFFF_FFFD});
      issue(0, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2, 1'b0, 33);
      finish_op(0, 0, {32'hFFFF_FFFE, 32'd2});
      issue(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33);
      finish_op(0, 0, {32'd0, 32'h8000_0000});
      issue(0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, EO1);
      finish_op(0, 0, {32'h8000_0000, 32'd0});

      // divide by zero, result held 10 cycles before ack
      issue(0, 1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1);
      finish_op(0, 10, {32'd5, 32'hFFFF_FFFF});
      issue(0, 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1);
      finish_op(0, 0, {32'hFFFF_FFFB, 32'hFFFF_FFFF});

      // annul at CALC edge 10
      drive(0, 1'b0, 32'd1000, 32'd3, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      drive(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      repeat (9) @(posedge clk); #1;
      drive(0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      @(posedge clk); #1;
      drive(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      chk("busy_after_annul", {63'd0, bi1.busy_o}, 0);
      repeat (40) @(posedge clk); #1;
      chk("no_ready_after_annul", {63'd0, bi1.ready_o}, 0);

      issue(0, 1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 33);
      finish_op(0, 0, {32'd0, 32'd3});
      issue(0, 1'b0, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, EO1);
      finish_op(0, 0, {32'd0, 32'd0});

      // two-bits-per-cycle instance
      issue(1, 1'b0, 32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF, 1'b0, 17);
      finish_op(1, 0, {32'd15, 32'h0FFF_FFFF});
      issue(1, 1'b0, 32'd3, 32'd10, 32'd3, 32'd0, 1'b0, EO2);
      finish_op(1, 0, {32'd3, 32'd0});
      issue(1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 17);
      finish_op(1, 0, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

      repeat (3) @(posedge clk); #1;
      chk("queue1_drained", q1.size(), 0);
      chk("queue2_drained", q2.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
